// File: rtl/mem_req_adapter_pkg.sv
// -----------------------------------------------------------------------------
// mem_req_adapter_pkg
// Shared types and helpers for the mem_system request adapter.
//   state_t      : adapter FSM encoding (IDLE/BUSY/RESP/ERR)
//   op_t         : latched operation of the in-flight request
//   DEFAULT_*    : default timeout configuration
//   is_malformed : request filter (double/empty op or odd byte address)
//   sat_inc16    : 16-bit saturating increment used by the statistics block
// Optional feature macro used by the importers: MEM_REQ_ADAPTER_STATS_EN.
// -----------------------------------------------------------------------------
package mem_req_adapter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10,
    ERR  = 2'b11
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int DEFAULT_TO_W           = 7;

  // A request is rejected when it asks for both or neither operation, or
  // targets an odd byte address (mem_system only handles 16-bit words).
  function automatic logic is_malformed(input logic rd, input logic wr,
                                        input logic addr_lsb);
    return (rd & wr) | (~rd & ~wr) | addr_lsb;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'h0001);
  endfunction

endpackage

// File: rtl/mem_req_adapter_stats.sv
// -----------------------------------------------------------------------------
// mem_req_adapter_stats
// Three saturating response counters, present only when the adapter is built
// with MEM_REQ_ADAPTER_STATS_EN.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   resp_fire_i      : one-cycle response pulse from the adapter
//   resp_hit_i       : response was a cache hit
//   resp_err_i       : response carries an error
//   stat_hits_o      : responses flagged as hits
//   stat_misses_o    : responses that were neither hit nor error
//   stat_errs_o      : responses flagged as errors
// -----------------------------------------------------------------------------
module mem_req_adapter_stats
  import mem_req_adapter_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        resp_fire_i,
  input  logic        resp_hit_i,
  input  logic        resp_err_i,
  output logic [15:0] stat_hits_o,
  output logic [15:0] stat_misses_o,
  output logic [15:0] stat_errs_o
);

  logic [15:0] hits_q;
  logic [15:0] misses_q;
  logic [15:0] errs_q;

  // Count each response once per category; all counters stick at 0xFFFF.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hits_q   <= 16'h0000;
      misses_q <= 16'h0000;
      errs_q   <= 16'h0000;
    end else if (resp_fire_i) begin
      if (resp_hit_i) begin
        hits_q <= sat_inc16(hits_q);
      end
      if (resp_err_i) begin
        errs_q <= sat_inc16(errs_q);
      end
      if (!resp_hit_i && !resp_err_i) begin
        misses_q <= sat_inc16(misses_q);
      end
    end
  end

  assign stat_hits_o   = hits_q;
  assign stat_misses_o = misses_q;
  assign stat_errs_o   = errs_q;

endmodule

// File: rtl/mem_req_adapter.sv
// -----------------------------------------------------------------------------
// mem_req_adapter
// Pipeline-side front end for mem_system. Accepts one load/store per
// valid/ready handshake, drives and holds Addr/DataIn/Rd/Wr until Done, and
// returns one registered response pulse. Malformed requests are answered with
// an error without touching memory; a sticky hang flag reports transactions
// that stay busy for TIMEOUT_CYCLES (the transaction itself is never aborted).
//
// Parameters: TIMEOUT_CYCLES (>= 2), TO_W (counter width, must hold
// TIMEOUT_CYCLES).
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   req_valid/req_ready              : core request handshake
//   req_rd, req_wr, req_addr, req_wdata : request op, byte address, store data
//   resp_valid, resp_data, resp_err, resp_hit : one-cycle response
//   mem_addr, mem_data_in, mem_rd, mem_wr     : to mem_system
//   mem_data_out, mem_done, mem_stall, mem_cache_hit, mem_err : from mem_system
//   hang_o                           : sticky timeout flag
// Optional (macro MEM_REQ_ADAPTER_STATS_EN): stat_hits, stat_misses, stat_errs.
// -----------------------------------------------------------------------------
module mem_req_adapter
  import mem_req_adapter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TO_W           = DEFAULT_TO_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_err,
  output logic        resp_hit,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_data_out,
  input  logic        mem_done,
  input  logic        mem_stall,
  input  logic        mem_cache_hit,
  input  logic        mem_err,
  output logic        hang_o
`ifdef MEM_REQ_ADAPTER_STATS_EN
  ,
  output logic [15:0] stat_hits,
  output logic [15:0] stat_misses,
  output logic [15:0] stat_errs
`endif
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

  state_t            state_q;
  op_t               op_q;
  logic              err_sticky_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [15:0]       resp_data_q;
  logic              resp_err_q;
  logic              resp_hit_q;
  logic [15:0]       mem_addr_q;
  logic [15:0]       mem_data_in_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic              hang_q;

  logic              malformed_d;
  logic [TO_W-1:0]   to_cnt_d;
  logic              err_acc_d;
  logic [15:0]       load_data_d;

  // Stall is observed only; it never steers the FSM.
  logic              unused_stall_s;
  assign unused_stall_s = mem_stall;

  // Next-value helpers: request filter, saturating timeout count, error
  // accumulation and the data word a completing transaction returns.
  always_comb begin
    malformed_d = is_malformed(req_rd, req_wr, req_addr[0]);
    err_acc_d   = err_sticky_q | mem_err;
    if (to_cnt_q == TO_LIMIT) begin
      to_cnt_d = to_cnt_q;
    end else begin
      to_cnt_d = to_cnt_q + TO_ONE;
    end
    // Stores and failed loads return zero.
    if ((op_q == OP_RD) && !err_acc_d) begin
      load_data_d = mem_data_out;
    end else begin
      load_data_d = 16'h0000;
    end
  end

  // Adapter FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= OP_RD;
      err_sticky_q  <= 1'b0;
      to_cnt_q      <= {TO_W{1'b0}};
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= 16'h0000;
      resp_err_q    <= 1'b0;
      resp_hit_q    <= 1'b0;
      mem_addr_q    <= 16'h0000;
      mem_data_in_q <= 16'h0000;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      hang_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          to_cnt_q <= {TO_W{1'b0}};
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            if (malformed_d) begin
              state_q      <= ERR;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_hit_q   <= 1'b0;
              resp_data_q  <= 16'h0000;
            end else begin
              state_q       <= BUSY;
              op_q          <= req_wr ? OP_WR : OP_RD;
              err_sticky_q  <= 1'b0;
              mem_addr_q    <= req_addr;
              mem_data_in_q <= req_wdata;
              mem_rd_q      <= req_rd;
              mem_wr_q      <= req_wr;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end

        BUSY: begin
          // The hang flag only reports; the access keeps running because the
          // cache controller may be in the middle of a writeback.
          if (to_cnt_d == TO_LIMIT) begin
            hang_q <= 1'b1;
          end
          if (mem_done) begin
            state_q      <= RESP;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            to_cnt_q     <= {TO_W{1'b0}};
            err_sticky_q <= err_acc_d;
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_acc_d;
            resp_hit_q   <= mem_cache_hit;
            resp_data_q  <= load_data_d;
          end else begin
            to_cnt_q     <= to_cnt_d;
            err_sticky_q <= err_acc_d;
          end
        end

        RESP, ERR: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_hit_q   <= 1'b0;
          resp_data_q  <= 16'h0000;
        end

        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_hit_q   <= 1'b0;
          resp_data_q  <= 16'h0000;
          mem_rd_q     <= 1'b0;
          mem_wr_q     <= 1'b0;
          to_cnt_q     <= {TO_W{1'b0}};
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_err    = resp_err_q;
  assign resp_hit    = resp_hit_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign hang_o      = hang_q;

`ifdef MEM_REQ_ADAPTER_STATS_EN
  mem_req_adapter_stats u_stats (
    .clk_i         (clk),
    .rst_i         (rst),
    .resp_fire_i   (resp_valid_q),
    .resp_hit_i    (resp_hit_q),
    .resp_err_i    (resp_err_q),
    .stat_hits_o   (stat_hits),
    .stat_misses_o (stat_misses),
    .stat_errs_o   (stat_errs)
  );
`endif

endmodule

// File: tb/tb_mem_req_adapter.sv
// -----------------------------------------------------------------------------
// tb_mem_req_adapter
// Drives mem_req_adapter (TIMEOUT_CYCLES=8) with directed and random requests
// while emulating mem_system, and checks responses against a reference model
// of the request/response rules kept in plain arrays.
// -----------------------------------------------------------------------------
module tb_mem_req_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_rd, req_wr;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, resp_hit;
  logic [15:0] resp_data;
  logic [15:0] mem_addr, mem_data_in, mem_data_out;
  logic        mem_rd, mem_wr, mem_done, mem_stall, mem_cache_hit, mem_err;
  logic        hang_o;
`ifdef MEM_REQ_ADAPTER_STATS_EN
  logic [15:0] stat_hits, stat_misses, stat_errs;
`endif

  int tests_run;
  int tests_failed;

  // mem_system emulator state and the independent reference model state.
  bit [15:0] emu_mem    [0:65535];
  bit        emu_cached [0:65535];
  bit [15:0] ref_mem    [0:65535];
  bit        ref_cached [0:65535];

  typedef struct {
    bit          timed_out;
    bit          mem_active;
    bit          rd_seen;
    bit          wr_seen;
    bit          unstable;
    logic [15:0] addr_seen;
    logic [15:0] din_seen;
    int          busy_cycles;
    int          resp_count;
    int          resp_cycle;
    logic [15:0] resp_data;
    logic        resp_err;
    logic        resp_hit;
  } obs_t;

  mem_req_adapter #(.TIMEOUT_CYCLES(8), .TO_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err), .resp_hit(resp_hit),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_data_out(mem_data_out), .mem_done(mem_done), .mem_stall(mem_stall),
    .mem_cache_hit(mem_cache_hit), .mem_err(mem_err),
    .hang_o(hang_o)
`ifdef MEM_REQ_ADAPTER_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_errs(stat_errs)
`endif
  );

  always #5 clk = ~clk;

  // Reference: expected response of one request from the adapter rules.
  function automatic void ref_txn(input bit rd, input bit wr, input logic [15:0] addr,
                                  input logic [15:0] wdata, input bit inj_err,
                                  output bit mal, output logic [15:0] d,
                                  output bit e, output bit h);
    mal = (rd == wr) || addr[0];
    if (mal) begin
      d = 16'h0000; e = 1'b1; h = 1'b0;
    end else begin
      e = inj_err;
      h = ref_cached[addr];
      ref_cached[addr] = 1'b1;
      if (wr) begin
        ref_mem[addr] = wdata;
        d = 16'h0000;
      end else begin
        d = e ? 16'h0000 : ref_mem[addr];
      end
    end
  endfunction

  // Issue one request and play mem_system; returns what was observed.
  task automatic run_req(input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input int latency, input bit inj_err,
                         output obs_t o);
    int  cnt;
    int  busy;
    int  after;
    bit  done_sent;
    o.timed_out = 0; o.mem_active = 0; o.rd_seen = 0; o.wr_seen = 0; o.unstable = 0;
    o.addr_seen = 16'h0000; o.din_seen = 16'h0000; o.busy_cycles = 0;
    o.resp_count = 0; o.resp_cycle = 0; o.resp_data = 16'h0000;
    o.resp_err = 1'b0; o.resp_hit = 1'b0;
    cnt = 0;
    while (!req_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (!req_ready) begin
      o.timed_out = 1;
      return;
    end
    req_valid = 1'b1; req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_rd = 1'($urandom); req_wr = 1'($urandom);
    req_addr = 16'($urandom); req_wdata = 16'($urandom);
    busy = 0; after = 0; done_sent = 0;
    for (int c = 1; c <= 40; c++) begin
      if (mem_rd || mem_wr) begin
        if (busy == 0) begin
          o.addr_seen = mem_addr; o.din_seen = mem_data_in;
          o.rd_seen = mem_rd; o.wr_seen = mem_wr;
        end else if (mem_addr !== o.addr_seen || mem_data_in !== o.din_seen ||
                     mem_rd !== o.rd_seen || mem_wr !== o.wr_seen) begin
          o.unstable = 1;
        end
        o.mem_active = 1;
        busy++;
      end
      if (resp_valid) begin
        if (o.resp_count == 0) begin
          o.resp_cycle = c; o.resp_data = resp_data;
          o.resp_err = resp_err; o.resp_hit = resp_hit;
        end
        o.resp_count++;
      end
      mem_done = 1'b0; mem_err = 1'b0; mem_stall = 1'($urandom);
      mem_cache_hit = 1'($urandom); mem_data_out = 16'($urandom);
      if ((mem_rd || mem_wr) && !done_sent) begin
        if (inj_err && busy == 1) mem_err = 1'b1;
        if (busy == latency) begin
          mem_done = 1'b1; done_sent = 1;
          mem_cache_hit = emu_cached[mem_addr];
          if (mem_rd) mem_data_out = emu_mem[mem_addr];
          else emu_mem[mem_addr] = mem_data_in;
          emu_cached[mem_addr] = 1'b1;
        end
      end
      if (o.resp_count > 0) after++;
      if (after >= 3) break;
      @(negedge clk);
    end
    mem_done = 1'b0; mem_err = 1'b0;
    o.busy_cycles = busy;
    if (o.resp_count == 0) o.timed_out = 1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({req_ready, resp_valid, resp_err, resp_hit, mem_rd, mem_wr, hang_o} !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 1000000",
               {req_ready, resp_valid, resp_err, resp_hit, mem_rd, mem_wr, hang_o});
    end
    tests_run++;
    if ({resp_data, mem_addr, mem_data_in} !== 48'h0) begin
      tests_failed++;
      $display("FAIL reset_buses: got %h want 0", {resp_data, mem_addr, mem_data_in});
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_idle_noise;
    bit bad = 0;
    for (int c = 0; c < 4; c++) begin
      mem_done = 1'b1; mem_err = 1'b1;
      @(negedge clk);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_rd !== 1'b0) bad = 1;
    end
    mem_done = 1'b0; mem_err = 1'b0;
    @(negedge clk);
    if (resp_valid !== 1'b0) bad = 1;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL idle_done_ignored: got response/ready change want none");
    end
  endtask

  task automatic test_read_hit;
    obs_t o;
    emu_mem[16'h0010] = 16'hBEEF; ref_mem[16'h0010] = 16'hBEEF;
    emu_cached[16'h0010] = 1'b1; ref_cached[16'h0010] = 1'b1;
    run_req(1'b1, 1'b0, 16'h0010, 16'h0000, 3, 1'b0, o);
    tests_run++;
    if (o.resp_data !== 16'hBEEF || o.resp_hit !== 1'b1 || o.resp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_hit_resp: got data=%h hit=%b err=%b want BEEF 1 0",
               o.resp_data, o.resp_hit, o.resp_err);
    end
    tests_run++;
    if (o.busy_cycles != 3 || o.resp_cycle != 4 || o.resp_count != 1 || !o.rd_seen || o.timed_out) begin
      tests_failed++;
      $display("FAIL rd_hit_timing: got busy=%0d resp_at=%0d count=%0d want 3 4 1",
               o.busy_cycles, o.resp_cycle, o.resp_count);
    end
  endtask

  task automatic test_write_then_read;
    obs_t o;
    run_req(1'b0, 1'b1, 16'h2004, 16'h1234, 4, 1'b0, o);
    tests_run++;
    if (o.resp_data !== 16'h0000 || o.resp_hit !== 1'b0 || o.resp_err !== 1'b0 || o.resp_count != 1) begin
      tests_failed++;
      $display("FAIL wr_miss_resp: got data=%h hit=%b err=%b count=%0d want 0000 0 0 1",
               o.resp_data, o.resp_hit, o.resp_err, o.resp_count);
    end
    tests_run++;
    if (!o.wr_seen || o.rd_seen || o.unstable || o.addr_seen !== 16'h2004 || o.din_seen !== 16'h1234) begin
      tests_failed++;
      $display("FAIL wr_miss_bus: got addr=%h din=%h wr=%b unstable=%b want 2004 1234 1 0",
               o.addr_seen, o.din_seen, o.wr_seen, o.unstable);
    end
    run_req(1'b1, 1'b0, 16'h2004, 16'h0000, 2, 1'b0, o);
    tests_run++;
    if (o.resp_data !== 16'h1234 || o.resp_hit !== 1'b1 || o.unstable || o.addr_seen !== 16'h2004) begin
      tests_failed++;
      $display("FAIL rd_after_wr: got data=%h hit=%b unstable=%b want 1234 1 0",
               o.resp_data, o.resp_hit, o.unstable);
    end
  endtask

  task automatic test_misaligned;
    obs_t o;
    run_req(1'b1, 1'b0, 16'h0013, 16'h0000, 1, 1'b0, o);
    tests_run++;
    if (o.resp_cycle != 1 || o.resp_err !== 1'b1 || o.resp_data !== 16'h0000 || o.resp_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL misaligned_resp: got at=%0d err=%b data=%h hit=%b want 1 1 0000 0",
               o.resp_cycle, o.resp_err, o.resp_data, o.resp_hit);
    end
    tests_run++;
    if (o.mem_active || o.resp_count != 1) begin
      tests_failed++;
      $display("FAIL misaligned_no_access: got active=%b count=%0d want 0 1", o.mem_active, o.resp_count);
    end
  endtask

  task automatic test_malformed;
    obs_t o;
    run_req(1'b1, 1'b1, 16'h0000, 16'h5555, 1, 1'b0, o);
    tests_run++;
    if (o.resp_cycle != 1 || o.resp_err !== 1'b1 || o.mem_active || o.resp_count != 1) begin
      tests_failed++;
      $display("FAIL malformed_rdwr: got at=%0d err=%b active=%b want 1 1 0", o.resp_cycle, o.resp_err, o.mem_active);
    end
    run_req(1'b0, 1'b0, 16'h0002, 16'h5555, 1, 1'b0, o);
    tests_run++;
    if (o.resp_cycle != 1 || o.resp_err !== 1'b1 || o.mem_active) begin
      tests_failed++;
      $display("FAIL malformed_noop: got at=%0d err=%b active=%b want 1 1 0", o.resp_cycle, o.resp_err, o.mem_active);
    end
  endtask

  task automatic test_back_to_back;
    int resp_at[$];
    bit bad_data = 0;
    req_valid = 1'b1; req_rd = 1'b1; req_wr = 1'b0; req_addr = 16'h0010; req_wdata = 16'h0000;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        resp_at.push_back(c);
        if (resp_data !== 16'hBEEF || resp_hit !== 1'b1) bad_data = 1;
      end
      mem_done = mem_rd; mem_cache_hit = 1'b1; mem_data_out = emu_mem[mem_addr];
    end
    req_valid = 1'b0; mem_done = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (resp_at.size() != 4) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d responses want 4", resp_at.size());
    end else begin
      tests_run++;
      if (resp_at[0] != 2 || resp_at[1] != 5 || resp_at[2] != 8 || resp_at[3] != 11) begin
        tests_failed++;
        $display("FAIL b2b_spacing: got %0d %0d %0d %0d want 2 5 8 11",
                 resp_at[0], resp_at[1], resp_at[2], resp_at[3]);
      end
    end
    tests_run++;
    if (bad_data) begin
      tests_failed++;
      $display("FAIL b2b_data: got wrong data/hit want BEEF 1");
    end
  endtask

  task automatic test_reset_mid_busy;
    obs_t o;
    bit spurious = 0;
    req_valid = 1'b1; req_rd = 1'b1; req_wr = 1'b0; req_addr = 16'h3000;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1 || mem_rd !== 1'b0 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_busy: got ready=%b rd=%b valid=%b want 1 0 0", req_ready, mem_rd, resp_valid);
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) spurious = 1;
    end
    tests_run++;
    if (spurious) begin
      tests_failed++;
      $display("FAIL rst_no_resp: got resp_valid=1 want 0");
    end
    run_req(1'b1, 1'b0, 16'h0010, 16'h0000, 2, 1'b0, o);
    tests_run++;
    if (o.resp_data !== 16'hBEEF || o.resp_hit !== 1'b1 || o.resp_count != 1) begin
      tests_failed++;
      $display("FAIL rst_then_rd: got data=%h hit=%b count=%0d want BEEF 1 1", o.resp_data, o.resp_hit, o.resp_count);
    end
  endtask

  task automatic test_random;
    obs_t o;
    bit rd, wr, inj, mal, e, h;
    logic [15:0] addr, wdata, d;
    int lat, kind;
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 5);
      rd = (kind <= 1) || (kind == 4);
      wr = (kind == 2) || (kind == 3) || (kind == 4);
      addr = 16'h0100 + 16'($urandom_range(0, 7) * 2);
      if ($urandom_range(0, 5) == 0) addr = addr + 16'h0001;
      wdata = 16'($urandom);
      lat = $urandom_range(1, 6);
      inj = ($urandom_range(0, 3) == 0);
      ref_txn(rd, wr, addr, wdata, inj, mal, d, e, h);
      run_req(rd, wr, addr, wdata, lat, inj, o);
      tests_run++;
      if (o.resp_data !== d || o.resp_err !== e || o.resp_hit !== h || o.resp_count != 1) begin
        tests_failed++;
        $display("FAIL rand_resp[%0d]: got data=%h err=%b hit=%b cnt=%0d want %h %b %b 1",
                 n, o.resp_data, o.resp_err, o.resp_hit, o.resp_count, d, e, h);
      end
      tests_run++;
      if (o.resp_cycle != (mal ? 1 : lat + 1) || o.mem_active != !mal) begin
        tests_failed++;
        $display("FAIL rand_timing[%0d]: got at=%0d active=%b want %0d %b",
                 n, o.resp_cycle, o.mem_active, mal ? 1 : lat + 1, !mal);
      end
      if (!mal) begin
        tests_run++;
        if (o.unstable || o.addr_seen !== addr || o.rd_seen != rd || o.wr_seen != wr ||
            (wr && o.din_seen !== wdata)) begin
          tests_failed++;
          $display("FAIL rand_bus[%0d]: got addr=%h din=%h rd=%b wr=%b unstable=%b want %h %h %b %b 0",
                   n, o.addr_seen, o.din_seen, o.rd_seen, o.wr_seen, o.unstable, addr, wdata, rd, wr);
        end
      end
      tests_run++;
      if (hang_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand_no_hang[%0d]: got %b want 0", n, hang_o);
      end
    end
  endtask

  task automatic test_timeout;
    int  first_hang = 0;
    bit  rd_dropped = 0;
    bit  spurious   = 0;
    int  cnt = 0;
    while (!req_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    req_valid = 1'b1; req_rd = 1'b1; req_wr = 1'b0; req_addr = 16'h4000;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_done = 1'b0;
      if (hang_o === 1'b1 && first_hang == 0) first_hang = c;
      if (mem_rd !== 1'b1) rd_dropped = 1;
      if (resp_valid !== 1'b0) spurious = 1;
    end
    tests_run++;
    if (first_hang != 9) begin
      tests_failed++;
      $display("FAIL hang_rise: got first hang cycle %0d want 9", first_hang);
    end
    tests_run++;
    if (rd_dropped || spurious) begin
      tests_failed++;
      $display("FAIL hang_no_abort: got rd_dropped=%b resp=%b want 0 0", rd_dropped, spurious);
    end
    mem_done = 1'b1; mem_data_out = 16'h0000; mem_cache_hit = 1'b0;
    @(negedge clk);
    mem_done = 1'b0;
    tests_run++;
    if (resp_valid !== 1'b1 || hang_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL hang_late_done: got valid=%b hang=%b want 1 1", resp_valid, hang_o);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (hang_o !== 1'b1 || mem_rd !== 1'b0) begin
      tests_failed++;
      $display("FAIL hang_sticky: got hang=%b rd=%b want 1 0", hang_o, mem_rd);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (hang_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL hang_clear: got %b want 0", hang_o);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b1; req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
    req_addr = 16'h0000; req_wdata = 16'h0000;
    mem_data_out = 16'h0000; mem_done = 1'b0; mem_stall = 1'b0;
    mem_cache_hit = 1'b0; mem_err = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      emu_mem[i] = 16'(i) ^ 16'h5A5A;
      ref_mem[i] = 16'(i) ^ 16'h5A5A;
      emu_cached[i] = 1'b0;
      ref_cached[i] = 1'b0;
    end
    test_reset;
    test_idle_noise;
    test_read_hit;
    test_write_then_read;
    test_misaligned;
    test_malformed;
    test_back_to_back;
    test_reset_mid_busy;
    test_random;
    test_timeout;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
